// File: rtl/onehot_ring_counter_n.sv
// Parametrised one-hot ring counter: up/down stepping, parallel load, wrap pulse,
// binary index output and self-recovery from any non-one-hot state.
module onehot_ring_counter_n #(
  parameter int unsigned N          = 3,
  parameter int unsigned INIT_INDEX = 0,
  parameter int unsigned IW         = $clog2(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          up,
  input  logic          load,
  input  logic [IW-1:0] load_index,
  output logic [N-1:0]  q,
  output logic [IW-1:0] index,
  output logic          wrap,
  output logic          error
);

  localparam logic [N-1:0] INIT_Q = N'(1) << INIT_INDEX;

  logic [N-1:0] q_q, q_d;
  logic         wrap_q, wrap_d;

  // Zero hot bits, or clearing the lowest hot bit leaves another one set.
  always_comb begin
    error = (q_q == '0) || ((q_q & (q_q - N'(1))) != '0);
  end

  // OR of hot positions; exact whenever q_q is one-hot.
  always_comb begin
    index = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (q_q[i]) index = index | IW'(i);
    end
  end

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (error) begin
      q_d = INIT_Q;
    end else if (load) begin
      if (32'(load_index) < N) begin
        q_d             = '0;
        q_d[load_index] = 1'b1;
      end else begin
        q_d = INIT_Q;
      end
    end else if (enable) begin
      if (up) begin
        q_d    = {q_q[N-2:0], q_q[N-1]};
        wrap_d = q_q[N-1];
      end else begin
        q_d    = {q_q[0], q_q[N-1:1]};
        wrap_d = q_q[0];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q    <= INIT_Q;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_onehot_ring_counter_n.sv
// Directed self-checking bench for onehot_ring_counter_n at N=3, N=5 and N=4.
module tb_onehot_ring_counter_n;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // N=3 instance
  logic       en3 = 0, up3 = 0, ld3 = 0;
  logic [1:0] li3 = '0;
  logic [2:0] q3;
  logic [1:0] ix3;
  logic       wr3, er3;
  onehot_ring_counter_n #(.N(3), .INIT_INDEX(0)) dut3 (
    .clock(clk), .reset(rst), .enable(en3), .up(up3), .load(ld3), .load_index(li3),
    .q(q3), .index(ix3), .wrap(wr3), .error(er3)
  );

  // N=5 instance
  logic       en5 = 0, up5 = 0, ld5 = 0;
  logic [2:0] li5 = '0;
  logic [4:0] q5;
  logic [2:0] ix5;
  logic       wr5, er5;
  onehot_ring_counter_n #(.N(5), .INIT_INDEX(0)) dut5 (
    .clock(clk), .reset(rst), .enable(en5), .up(up5), .load(ld5), .load_index(li5),
    .q(q5), .index(ix5), .wrap(wr5), .error(er5)
  );

  // N=4 instance
  logic       en4 = 0, up4 = 0, ld4 = 0;
  logic [1:0] li4 = '0;
  logic [3:0] q4;
  logic [1:0] ix4;
  logic       wr4, er4;
  onehot_ring_counter_n #(.N(4), .INIT_INDEX(0)) dut4 (
    .clock(clk), .reset(rst), .enable(en4), .up(up4), .load(ld4), .load_index(li4),
    .q(q4), .index(ix4), .wrap(wr4), .error(er4)
  );

  initial begin
    // Asynchronous reset before the first clock edge (t=5)
    #2 rst = 1'b1;
    #1;
    chk("rst_q3",   32'(q3),  32'h1);
    chk("rst_ix3",  32'(ix3), 0);
    chk("rst_wr3",  32'(wr3), 0);
    chk("rst_er3",  32'(er3), 0);
    chk("rst_q5",   32'(q5),  32'h01);
    chk("rst_q4",   32'(q4),  32'h1);
    #1 rst = 1'b0;

    // N=3 counting up
    en3 = 1; up3 = 1;
    step; chk("up3_q1", 32'(q3), 32'b010); chk("up3_w1", 32'(wr3), 0); chk("up3_i1", 32'(ix3), 1);
    step; chk("up3_q2", 32'(q3), 32'b100); chk("up3_w2", 32'(wr3), 0); chk("up3_i2", 32'(ix3), 2);
    step; chk("up3_q3", 32'(q3), 32'b001); chk("up3_w3", 32'(wr3), 1); chk("up3_i3", 32'(ix3), 0);
    step; chk("up3_q4", 32'(q3), 32'b010); chk("up3_w4", 32'(wr3), 0);
    en3 = 0;

    // N=5 counting down from 00001
    en5 = 1; up5 = 0;
    step; chk("dn5_q1", 32'(q5), 32'b10000); chk("dn5_w1", 32'(wr5), 1); chk("dn5_i1", 32'(ix5), 4);
    step; chk("dn5_q2", 32'(q5), 32'b01000); chk("dn5_w2", 32'(wr5), 0); chk("dn5_i2", 32'(ix5), 3);
    step; chk("dn5_q3", 32'(q5), 32'b00100); chk("dn5_w3", 32'(wr5), 0); chk("dn5_i3", 32'(ix5), 2);

    // N=5 load beats enable; top legal index; out-of-range index goes to INIT
    ld5 = 1; li5 = 3'd3;
    step; chk("ld5_q3", 32'(q5), 32'b01000); chk("ld5_w3", 32'(wr5), 0); chk("ld5_i3", 32'(ix5), 3);
    li5 = 3'd4;
    step; chk("ld5_q4", 32'(q5), 32'b10000); chk("ld5_i4", 32'(ix5), 4);
    li5 = 3'd6;
    step; chk("ld5_q6", 32'(q5), 32'b00001); chk("ld5_w6", 32'(wr5), 0); chk("ld5_e6", 32'(er5), 0);
    ld5 = 0; en5 = 0;

    // N=4 advance once, then hold with enable low while up toggles
    en4 = 1; up4 = 1;
    step; chk("adv4_q", 32'(q4), 32'b0010);
    en4 = 0;
    for (int k = 0; k < 3; k++) begin
      up4 = ~up4;
      step;
      chk("hold4_q", 32'(q4), 32'b0010);
      chk("hold4_w", 32'(wr4), 0);
    end

    // N=4 illegal state: detected immediately, recovered in one edge despite load/enable
    force dut4.q_q = 4'b0110;
    #1;
    chk("bad4_err", 32'(er4), 1);
    release dut4.q_q;
    #1;
    chk("bad4_q",    32'(q4),  32'b0110);
    chk("bad4_err2", 32'(er4), 1);
    en4 = 1; up4 = 1; ld4 = 1; li4 = 2'd2;
    step; chk("rec4_q", 32'(q4), 32'b0001); chk("rec4_err", 32'(er4), 0); chk("rec4_w", 32'(wr4), 0);
    en4 = 0; ld4 = 0;

    // N=3 reset mid-count clears a live wrap pulse immediately
    en3 = 1; up3 = 1;
    step; chk("mid3_q1", 32'(q3), 32'b100);
    step; chk("mid3_q2", 32'(q3), 32'b001); chk("mid3_w2", 32'(wr3), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid3_rq", 32'(q3), 32'b001);
    chk("mid3_rw", 32'(wr3), 0);
    rst = 1'b0;
    step; chk("resume3_q", 32'(q3), 32'b010); chk("resume3_w", 32'(wr3), 0);
    en3 = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
